// File: rtl/spi_cmd_parser.sv
// spi_cmd_parser: turns SPI target byte traffic into register read/write strobes
//
// Ports
//   i_clk, i_rst_n      system clock, asynchronous active-low reset
//   i_frame_active      target selected (synchronized, active-high)
//   i_rx_data           received byte; i_rx_data_valid rising edge marks a new byte
//   i_tx_data_hold      target captures o_tx_data this cycle
//   o_tx_data           next MISO byte (read data, otherwise 0x00)
//   o_wr_en/addr/data   one-cycle register write strobe
//   o_rd_en/addr        one-cycle register read strobe; i_rd_data valid one cycle later
//   o_busy              parser outside IDLE
//   o_frame_err         one-cycle pulse on a protocol violation
//
// Build option
//   SPI_CMD_AUTOINC_EN  defined: unlimited bursts with auto-incrementing address;
//                       undefined: one data byte per frame, extras flag o_frame_err
module spi_cmd_parser #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_frame_active,
    input  logic [WIDTH-1:0] i_rx_data,
    input  logic             i_rx_data_valid,
    input  logic             i_tx_data_hold,
    output logic [WIDTH-1:0] o_tx_data,
    output logic             o_wr_en,
    output logic [6:0]       o_wr_addr,
    output logic [WIDTH-1:0] o_wr_data,
    output logic             o_rd_en,
    output logic [6:0]       o_rd_addr,
    input  logic [WIDTH-1:0] i_rd_data,
    output logic             o_busy,
    output logic             o_frame_err
);
    localparam logic [1:0] IDLE = 2'd0, CMD = 2'd1, WR = 2'd2, RD = 2'd3;
    logic [1:0]       state_q, state_d;
    logic             rx_valid_q, frame_q, rd_pend_q, byte_ev;
    logic             busy_q, busy_d, wr_en_q, wr_en_d, rd_en_q, rd_en_d, frame_err_q, frame_err_d;
    logic [6:0]       addr_q, addr_d, wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d, tx_data_q, tx_data_d;
`ifndef SPI_CMD_AUTOINC_EN
    logic             done_q, done_d;
`endif
    assign byte_ev = i_rx_data_valid & ~rx_valid_q;
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        frame_err_d = 1'b0;
        tx_data_d   = (state_q == RD) ? tx_data_q : '0;
`ifndef SPI_CMD_AUTOINC_EN
        done_d      = done_q;
`endif
        // Frame end wins over any byte event in the same cycle.
        if (!i_frame_active) begin
            state_d   = IDLE;
            tx_data_d = '0;
        end else begin
            case (state_q)
                // frame_q resets high, so a frame already running at reset release is skipped.
                IDLE: state_d = frame_q ? IDLE : CMD;
                CMD: if (byte_ev) begin
                    addr_d    = i_rx_data[6:0];
                    state_d   = i_rx_data[7] ? RD : WR;
                    rd_en_d   = i_rx_data[7];
                    rd_addr_d = i_rx_data[7] ? i_rx_data[6:0] : rd_addr_q;
`ifndef SPI_CMD_AUTOINC_EN
                    done_d    = 1'b0;
`endif
                end
                WR: if (byte_ev) begin
`ifdef SPI_CMD_AUTOINC_EN
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = i_rx_data;
                    addr_d    = addr_q + 7'd1;
`else
                    wr_en_d     = ~done_q;
                    wr_addr_d   = done_q ? wr_addr_q : addr_q;
                    wr_data_d   = done_q ? wr_data_q : i_rx_data;
                    frame_err_d = done_q;
                    done_d      = 1'b1;
`endif
                end
                default: if (i_tx_data_hold) begin
                    tx_data_d = '0;
`ifdef SPI_CMD_AUTOINC_EN
                    addr_d    = addr_q + 7'd1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = addr_q + 7'd1;
`else
                    frame_err_d = done_q;
                    done_d      = 1'b1;
`endif
                end else if (rd_pend_q) begin
                    tx_data_d = i_rd_data;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            rx_valid_q  <= 1'b0;
            frame_q     <= 1'b1;
            rd_pend_q   <= 1'b0;
            busy_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            frame_err_q <= 1'b0;
            addr_q      <= '0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            wr_data_q   <= '0;
            tx_data_q   <= '0;
`ifndef SPI_CMD_AUTOINC_EN
            done_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rx_valid_q  <= i_rx_data_valid;
            frame_q     <= i_frame_active;
            rd_pend_q   <= rd_en_q;
            busy_q      <= busy_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            frame_err_q <= frame_err_d;
            addr_q      <= addr_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            wr_data_q   <= wr_data_d;
            tx_data_q   <= tx_data_d;
`ifndef SPI_CMD_AUTOINC_EN
            done_q      <= done_d;
`endif
        end
    end
    assign o_tx_data   = tx_data_q;
    assign o_wr_en     = wr_en_q;
    assign o_wr_addr   = wr_addr_q;
    assign o_wr_data   = wr_data_q;
    assign o_rd_en     = rd_en_q;
    assign o_rd_addr   = rd_addr_q;
    assign o_busy      = busy_q;
    assign o_frame_err = frame_err_q;
endmodule

// File: doc/spi_cmd_parser.md
SPI_CMD_PARSER -- requirements
Module: spi_cmd_parser

Interface
REQ-001 SHALL have parameter: WIDTH, 8, SPI byte width (only 8 supported).
REQ-002 SHALL have port: i_clk  input  1  system clock.
REQ-003 SHALL have port: i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: i_frame_active  input  1  high while SPI target is selected (synchronized, active-high).
REQ-005 SHALL have port: i_rx_data  input  8  byte from SPI target.
REQ-006 SHALL have port: i_rx_data_valid  input  1  level; rising edge marks a new received byte.
REQ-007 SHALL have port: i_tx_data_hold  input  1  pulse; SPI target captures o_tx_data this cycle.
REQ-008 SHALL have port: o_tx_data  output  8  next byte to shift out on MISO.
REQ-009 SHALL have port: o_wr_en  output  1  one-cycle register write strobe.
REQ-010 SHALL have port: o_wr_addr  output  7  write address.
REQ-011 SHALL have port: o_wr_data  output  8  write data.
REQ-012 SHALL have port: o_rd_en  output  1  one-cycle register read strobe.
REQ-013 SHALL have port: o_rd_addr  output  7  read address.
REQ-014 SHALL have port: i_rd_data  input  8  read data, valid exactly 1 cycle after o_rd_en.
REQ-015 SHALL have port: o_busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port: o_frame_err  output  1  one-cycle pulse on a protocol violation.

Function
REQ-017 SHALL detect a byte event as i_rx_data_valid high while its registered copy is low; one event per byte.
REQ-018 SHALL implement states IDLE, CMD, WR, RD; all outputs registered.
REQ-019 SHALL go IDLE->CMD when i_frame_active rises; any state ->IDLE the cycle after i_frame_active is low; byte events in IDLE are ignored.
REQ-020 SHALL decode the first byte in CMD: bit7=1 read, bit7=0 write, bits[6:0] = start address, latched into an internal address register.
REQ-021 SHALL on a write command go CMD->WR; on each WR byte event pulse o_wr_en the next cycle with o_wr_addr = address, o_wr_data = byte.
REQ-022 SHALL on a read command go CMD->RD and pulse o_rd_en the cycle after the command byte event with o_rd_addr = address.
REQ-023 SHALL load o_tx_data with i_rd_data the cycle after the read data is valid (2 cycles after o_rd_en).
REQ-024 SHALL drive o_tx_data = 0x00 in IDLE, CMD, and WR, and after any i_tx_data_hold that is not followed by a new read.
REQ-025 SHALL ignore byte events in RD (MOSI content is don't-care during reads).
REQ-026 SHALL give priority to the frame end over a byte event arriving in the same cycle; no bus strobe is issued for that byte.
REQ-027 SHALL never assert o_wr_en and o_rd_en in the same cycle.
REQ-028 SHALL require i_clk >= 8x SCK, so read data is ready before the next i_tx_data_hold.

Reset
REQ-029 SHALL, on i_rst_n low, asynchronously force state IDLE and all outputs and the internal address to 0, including mid-frame.
REQ-030 SHALL, after reset release, ignore the frame in progress until i_frame_active has been observed low.

Configuration
REQ-031 SHALL use the macro SPI_CMD_AUTOINC_EN to control burst access.
- Defined: the address increments after each WR write and after each RD i_tx_data_hold, and the next read is issued in the hold cycle; 0x7F wraps to 0x00; bursts are unlimited.
- Undefined: one data byte per frame. A second WR byte event, or a second i_tx_data_hold in RD, pulses o_frame_err and is ignored (no strobe; o_tx_data = 0x00).

Verification
REQ-032 SHALL cover a write frame: bytes 0x05, 0xA5 -> one o_wr_en with addr 0x05, data 0xA5, and o_rd_en never asserted.
REQ-033 SHALL cover a read frame: byte 0x85 with the model returning 0x3C -> o_rd_en with addr 0x05; o_tx_data = 0x3C before the next hold; MISO byte 2 = 0x3C.
REQ-034 SHALL cover an AUTOINC burst: write 0x7E, then 0x11, 0x22, 0x33 -> writes to 0x7E, 0x7F, 0x00; without the macro, one write plus two o_frame_err pulses.
REQ-035 SHALL cover a frame abort: i_frame_active drops in the same cycle as the data-byte event -> no o_wr_en; state IDLE; o_busy low next cycle.
REQ-036 SHALL cover reset mid-read: i_rst_n asserted in RD -> all outputs 0 immediately; the remainder of the frame is ignored until i_frame_active is low.
